// File: rtl/tc_sram_stream_adapter.sv
// tc_sram_stream_adapter: valid/ready request front-end for a tc_sram port.
// Reads are tracked through the SRAM latency into a credit-protected response FIFO.
module tc_sram_stream_adapter #(
    parameter  int unsigned NumWords  = 1024,
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned ByteWidth = 8,
    parameter  int unsigned Latency   = 1,
    parameter  int unsigned RespDepth = 4,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned CntWidth  = $clog2(RespDepth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [DataWidth-1:0] resp_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i,
    output logic [CntWidth-1:0]  outstanding_o
);

    localparam int unsigned PipeW    = (Latency >= 1) ? Latency : 1;
    localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    if (Latency < 1) begin : g_bad_latency
        $error("tc_sram_stream_adapter: Latency must be >= 1");
    end
    if (RespDepth < 1) begin : g_bad_depth
        $error("tc_sram_stream_adapter: RespDepth must be >= 1");
    end

    logic [PipeW-1:0]     pipe_q, pipe_d;
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]  count_q, outstanding_q;
    logic [DataWidth-1:0] mem_q [RespDepth];
    logic                 credit_ok, read_accept, push, pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RespDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts reads in flight plus FIFO occupancy, so a freed slot
    // only becomes usable the cycle after the pop.
    assign credit_ok     = (outstanding_q != CntWidth'(RespDepth));
    assign req_ready_o   = !rst_i && (req_we_i || credit_ok);

    assign sram_req_o    = req_valid_i && req_ready_o;
    assign sram_we_o     = sram_req_o && req_we_i;
    assign sram_addr_o   = sram_req_o ? req_addr_i  : '0;
    assign sram_wdata_o  = sram_req_o ? req_wdata_i : '0;
    assign sram_be_o     = sram_req_o ? req_be_i    : '0;

    assign read_accept   = sram_req_o && !req_we_i;
    assign push          = pipe_q[0];
    assign resp_valid_o  = (count_q != '0);
    assign pop           = resp_valid_o && resp_ready_i;
    assign resp_rdata_o  = mem_q[rd_ptr_q];
    assign outstanding_o = outstanding_q;

    always_comb begin
        pipe_d          = pipe_q >> 1;
        pipe_d[PipeW-1] = pipe_d[PipeW-1] | read_accept;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
        end else begin
            pipe_q <= pipe_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (read_accept && !pop)      outstanding_q <= outstanding_q + 1'b1;
            else if (pop && !read_accept) outstanding_q <= outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) mem_q[wr_ptr_q] <= sram_rdata_i;
    end

`ifndef SYNTHESIS
    a_no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && count_q == CntWidth'(RespDepth)))
        else $error("tc_sram_stream_adapter: push into full response FIFO");

    a_addr_in_range : assert property (@(posedge clk_i) disable iff (rst_i)
        !(sram_req_o && (64'(req_addr_i) >= 64'(NumWords))))
        else $error("tc_sram_stream_adapter: address beyond NumWords");
`endif

endmodule

// File: tb/tb_tc_sram_stream_adapter.sv
// Bench for tc_sram_stream_adapter: two configurations (Latency 1/depth 4, Latency 2/depth 3),
// queue-based reference model per instance, directed tables and randomized traffic.
module tb_tc_sram_stream_adapter;

    localparam int unsigned NW = 1024;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned BW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst        [2];
    logic          req_valid  [2];
    logic          req_we     [2];
    logic [AW-1:0] req_addr   [2];
    logic [DW-1:0] req_wdata  [2];
    logic [BW-1:0] req_be     [2];
    logic          resp_ready [2];
    logic          req_ready  [2];
    logic          resp_valid [2];
    logic [DW-1:0] resp_rdata [2];
    int unsigned   outst      [2];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL i%0d.%s: got %0h expected %0h", g, nm, act, exp);
        end
    endtask

    task automatic timeout(input int g, input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL i%0d.%s: no completion within cycle bound", g, nm);
    endtask

    function automatic logic [DW-1:0] pat(input int g, input int i);
        return 32'hC0DE0000 | (32'(g) << 8) | 32'(i);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned L  = (g == 0) ? 1 : 2;
        localparam int unsigned D  = (g == 0) ? 4 : 3;
        localparam int unsigned CW = $clog2(D + 1);

        logic          sram_req, sram_we;
        logic [AW-1:0] sram_addr;
        logic [DW-1:0] sram_wdata, sram_rdata;
        logic [BW-1:0] sram_be;
        logic [CW-1:0] out_w;
        logic          rv, rr;
        logic [DW-1:0] rd;

        tc_sram_stream_adapter #(
            .NumWords (NW),
            .DataWidth(DW),
            .ByteWidth(8),
            .Latency  (L),
            .RespDepth(D)
        ) dut (
            .clk_i        (clk),
            .rst_i        (rst[g]),
            .req_valid_i  (req_valid[g]),
            .req_ready_o  (rr),
            .req_we_i     (req_we[g]),
            .req_addr_i   (req_addr[g]),
            .req_wdata_i  (req_wdata[g]),
            .req_be_i     (req_be[g]),
            .resp_valid_o (rv),
            .resp_ready_i (resp_ready[g]),
            .resp_rdata_o (rd),
            .sram_req_o   (sram_req),
            .sram_we_o    (sram_we),
            .sram_addr_o  (sram_addr),
            .sram_wdata_o (sram_wdata),
            .sram_be_o    (sram_be),
            .sram_rdata_i (sram_rdata),
            .outstanding_o(out_w)
        );

        assign req_ready[g]  = rr;
        assign resp_valid[g] = rv;
        assign resp_rdata[g] = rd;
        assign outst[g]      = 32'(out_w);

        // SRAM with a fixed read latency of L cycles
        logic [DW-1:0] mem   [NW];
        logic [DW-1:0] rpipe [L];
        always @(posedge clk) begin
            if (sram_req && sram_we)
                for (int b = 0; b < BW; b++)
                    if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            if (sram_req && !sram_we) rpipe[0] <= mem[sram_addr];
            for (int s = 1; s < L; s++) rpipe[s] <= rpipe[s-1];
        end
        assign sram_rdata = rpipe[L-1];

        // Reference model: a queue of accepted reads with their accept edge and expected data
        int unsigned   edges = 0;
        always @(posedge clk) edges <= edges + 1;

        int unsigned   q_acc [$];
        logic [DW-1:0] q_dat [$];
        logic [DW-1:0] shadow [NW];
        bit            armed = 1'b0;

        always @(negedge clk) begin
            bit exp_v, exp_rdy, exp_req;
            exp_v   = 1'b0;
            exp_rdy = 1'b0;
            exp_req = 1'b0;
            if (armed) begin
                exp_v   = (q_acc.size() > 0) && (q_acc[0] + L <= edges);
                exp_rdy = !rst[g] && (req_we[g] || q_acc.size() < D);
                exp_req = req_valid[g] && exp_rdy;
                check(g, "resp_valid", rv, exp_v);
                if (exp_v) check(g, "resp_rdata", rd, q_dat[0]);
                check(g, "outstanding", outst[g], q_acc.size());
                check(g, "req_ready", rr, exp_rdy);
                check(g, "sram_req", sram_req, exp_req);
                check(g, "sram_we", sram_we, exp_req && req_we[g]);
                check(g, "sram_addr", sram_addr, exp_req ? req_addr[g] : '0);
                check(g, "sram_wdata", sram_wdata, exp_req ? req_wdata[g] : '0);
                check(g, "sram_be", sram_be, exp_req ? req_be[g] : '0);
            end
            if (rst[g]) begin
                q_acc.delete();
                q_dat.delete();
                armed = 1'b1;
            end else if (armed) begin
                if (exp_v && resp_ready[g]) begin
                    void'(q_acc.pop_front());
                    void'(q_dat.pop_front());
                end
                if (exp_req && req_we[g]) begin
                    for (int b = 0; b < BW; b++)
                        if (req_be[g][b]) shadow[req_addr[g]][b*8 +: 8] = req_wdata[g][b*8 +: 8];
                end else if (exp_req) begin
                    q_acc.push_back(edges + 1);
                    q_dat.push_back(shadow[req_addr[g]]);
                end
            end
        end
    end

    task automatic idle(input int g);
        req_valid[g] = 1'b0;
        req_we[g]    = 1'b0;
        req_addr[g]  = '0;
        req_wdata[g] = '0;
        req_be[g]    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int g, input logic we, input int unsigned a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
        int unsigned w;
        w = 0;
        req_valid[g] = 1'b1;
        req_we[g]    = we;
        req_addr[g]  = AW'(a);
        req_wdata[g] = d;
        req_be[g]    = be;
        @(negedge clk);
        while (!req_ready[g] && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!req_ready[g]) timeout(g, "issue");
        tick();
        idle(g);
    endtask

    task automatic drain(input int g);
        int unsigned w;
        w = 0;
        idle(g);
        resp_ready[g] = 1'b1;
        while (outst[g] != 0 && w < 60) begin
            tick();
            w++;
        end
        if (outst[g] != 0) timeout(g, "drain");
    endtask

    task automatic reset_test(input int g, input int unsigned lat);
        resp_ready[g] = 1'b0;
        issue(g, 1'b0, 1, '0, '0);
        issue(g, 1'b0, 2, '0, '0);
        rst[g] = 1'b1;
        repeat (3) tick();
        rst[g] = 1'b0;
        for (int c = 0; c < 2 * lat; c++) begin
            @(negedge clk);
            check(g, $sformatf("rst_valid%0d", c), resp_valid[g], 1'b0);
            check(g, $sformatf("rst_outst%0d", c), outst[g], 0);
            check(g, $sformatf("rst_ready%0d", c), req_ready[g], 1'b1);
        end
        tick();
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int unsigned   acc, n, early;
        int            pop_c, acc5_c;
        bit            got_v;
        logic [DW-1:0] got [$];

        tbl[0]  = '{1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 10'h010, 32'h0,        4'h0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 10'h020, 32'hFFFFFFFF, 4'hF, 32'h0};
        tbl[3]  = '{1'b1, 10'h020, 32'h00000000, 4'h5, 32'h0};
        tbl[4]  = '{1'b0, 10'h020, 32'h0,        4'h0, 32'hFF00FF00};
        tbl[5]  = '{1'b1, 10'h021, 32'h12345678, 4'hF, 32'h0};
        tbl[6]  = '{1'b1, 10'h021, 32'hAABBCCDD, 4'h2, 32'h0};
        tbl[7]  = '{1'b0, 10'h021, 32'h0,        4'h0, 32'h1234CC78};
        tbl[8]  = '{1'b1, 10'h3FF, 32'hCAFEF00D, 4'hF, 32'h0};
        tbl[9]  = '{1'b0, 10'h3FF, 32'h0,        4'h0, 32'hCAFEF00D};
        tbl[10] = '{1'b1, 10'h010, 32'h00000000, 4'h0, 32'h0};
        tbl[11] = '{1'b0, 10'h010, 32'h0,        4'h0, 32'hDEADBEEF};

        for (int g = 0; g < 2; g++) begin
            idle(g);
            rst[g]        = 1'b1;
            resp_ready[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) rst[g] = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check(g, "init_ready", req_ready[g], 1'b1);
            check(g, "init_valid", resp_valid[g], 1'b0);
            check(g, "init_outst", outst[g], 0);
        end
        tick();

        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 20; i++) issue(g, 1'b1, i, pat(g, i), 4'hF);

        reset_test(0, 1);
        reset_test(1, 2);

        // Directed write/read table on the Latency=1 instance
        resp_ready[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be);
            if (!tbl[i].we) begin
                n = 0;
                got_v = 1'b0;
                while (n < 20 && !got_v) begin
                    @(negedge clk);
                    n++;
                    if (resp_valid[0]) got_v = 1'b1;
                end
                if (!got_v) timeout(0, $sformatf("tbl%0d_resp", i));
                else begin
                    check(0, $sformatf("tbl%0d_latency", i), n, 2);
                    check(0, $sformatf("tbl%0d_rdata", i), resp_rdata[0], tbl[i].exp);
                end
                tick();
            end
        end

        // Credit stall: six reads against four slots with the consumer blocked
        resp_ready[0] = 1'b0;
        acc = 0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
            tick();
            if (acc >= 6) req_valid[0] = 1'b0;
            else req_addr[0] = AW'(acc);
        end
        @(negedge clk);
        check(0, "stall_accepts", acc, 4);
        check(0, "stall_ready", req_ready[0], 1'b0);
        check(0, "stall_outst", outst[0], 4);
        tick();
        req_we[0]    = 1'b1;
        req_addr[0]  = 10'h030;
        req_wdata[0] = 32'h600DCAFE;
        req_be[0]    = 4'hF;
        @(negedge clk);
        check(0, "stall_write_ready", req_ready[0], 1'b1);
        tick();
        req_we[0]     = 1'b0;
        req_addr[0]   = AW'(acc);
        resp_ready[0] = 1'b1;
        pop_c  = -1;
        acc5_c = -1;
        got.delete();
        for (int c = 0; c < 40 && (acc < 6 || outst[0] != 0); c++) begin
            @(negedge clk);
            if (resp_valid[0]) begin
                if (pop_c < 0) pop_c = c;
                got.push_back(resp_rdata[0]);
            end
            if (req_valid[0] && req_ready[0]) begin
                if (acc5_c < 0) acc5_c = c;
                acc++;
            end
            tick();
            if (acc >= 6) req_valid[0] = 1'b0;
            else req_addr[0] = AW'(acc);
        end
        idle(0);
        check(0, "release_first_pop", pop_c, 0);
        check(0, "release_5th_accept", acc5_c, pop_c + 1);
        check(0, "release_count", got.size(), 6);
        for (int i = 0; i < got.size() && i < 6; i++)
            check(0, $sformatf("release_data%0d", i), got[i], pat(0, i));

        // Streaming reads on the Latency=2 / depth 3 instance
        resp_ready[1] = 1'b1;
        got.delete();
        acc   = 0;
        early = 0;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = '0;
        for (int c = 0; c < 200 && got.size() < 20; c++) begin
            @(negedge clk);
            if (resp_valid[1]) got.push_back(resp_rdata[1]);
            if (req_valid[1] && req_ready[1]) begin
                acc++;
                if (c < 3) early++;
            end
            tick();
            if (acc >= 20) req_valid[1] = 1'b0;
            else req_addr[1] = AW'(acc);
        end
        idle(1);
        check(1, "stream_accepts", acc, 20);
        check(1, "stream_back_to_back", early, 3);
        check(1, "stream_resps", got.size(), 20);
        for (int i = 0; i < got.size() && i < 20; i++)
            check(1, $sformatf("stream_data%0d", i), got[i], pat(1, i));
        drain(1);

        // Randomized traffic on both instances, checked by the reference models
        for (int c = 0; c < 400; c++) begin
            for (int g = 0; g < 2; g++) begin
                req_valid[g]  = ($urandom_range(0, 3) != 0);
                req_we[g]     = ($urandom_range(0, 3) == 0);
                req_addr[g]   = AW'($urandom_range(0, 15));
                req_wdata[g]  = $urandom;
                req_be[g]     = BW'($urandom_range(0, 15));
                resp_ready[g] = ($urandom_range(0, 2) != 0);
            end
            tick();
        end
        drain(0);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
